// File: rtl/perf_event_counter_bank.sv
// Bank of NUM_CH event counters (wrap or saturate) with an atomic snapshot shadow bank and indexed read.
// Define PERF_OVF_IRQ_EN to build the sticky per-channel overflow flags and irq_o.
module perf_event_counter_bank #(
    parameter int NUM_CH   = 8,
    parameter int CNT_W    = 32,
    parameter int INC_W    = 2,
    parameter int SAT_MODE = 0,
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic [NUM_CH*INC_W-1:0] evt_inc_i,
    input  logic                    snap_req_i,
    input  logic                    rd_req_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic                    rd_valid_o,
    output logic [CNT_W-1:0]        rd_data_o,
    output logic                    rd_err_o,
    output logic                    snap_valid_o,
    output logic [NUM_CH-1:0]       ovf_o,
    output logic                    irq_o
);

    typedef enum logic {EMPTY, VALID} snap_state_e;

    snap_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic [CNT_W-1:0] cnt_d    [NUM_CH];
    logic [CNT_W-1:0] shadow_q [NUM_CH];
    logic [CNT_W:0]   sum      [NUM_CH];
    logic             rd_valid_q, rd_err_q, rd_err;
    logic [CNT_W-1:0] rd_data_q;

    // The extra top bit of each sum is the channel's carry-out (overflow event).
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sum[k]   = {1'b0, cnt_q[k]} + (CNT_W+1)'(evt_inc_i[k*INC_W +: INC_W]);
            cnt_d[k] = cnt_q[k];
            if (clr_i) begin
                cnt_d[k] = '0;
            end else if (en_i) begin
                if (SAT_MODE != 0 && sum[k][CNT_W]) cnt_d[k] = '1;
                else                                cnt_d[k] = sum[k][CNT_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (snap_req_i) state_d = VALID;
            VALID:   state_d = VALID;
            default: state_d = EMPTY;
        endcase
    end

    assign rd_err = (state_q == EMPTY) || (int'(rd_idx_i) >= NUM_CH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_req_i;
            rd_err_q   <= rd_req_i & rd_err;
            if (rd_req_i) begin
                rd_data_q <= rd_err ? '0 : shadow_q[rd_idx_i];
            end
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
                // Capture pre-edge live values; this cycle's inc/clr are not seen.
                if (snap_req_i) shadow_q[k] <= cnt_q[k];
            end
        end
    end

    assign rd_valid_o   = rd_valid_q;
    assign rd_err_o     = rd_err_q;
    assign rd_data_o    = rd_data_q;
    assign snap_valid_o = (state_q == VALID);

`ifdef PERF_OVF_IRQ_EN
    logic [NUM_CH-1:0] ovf_evt, ovf_d, ovf_q;
    logic              irq_q;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ovf_evt[k] = en_i & ~clr_i & sum[k][CNT_W];
        end
    end

    // A snapshot clears the flags, but an overflow in the same cycle wins.
    assign ovf_d = (snap_req_i ? '0 : ovf_q) | ovf_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            irq_q <= |ovf_d;
        end
    end

    assign ovf_o = ovf_q;
    assign irq_o = irq_q;
`else
    assign ovf_o = '0;
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Bench for perf_event_counter_bank: wrap and saturate instances driven in parallel,
// checked against an arithmetic model of counters, shadow bank and read port.
module tb_perf_event_counter_bank;

    localparam int NCH = 6;
    localparam int CW  = 8;
    localparam int IW  = 2;
    localparam int MAXV = (1 << CW) - 1;
`ifdef PERF_OVF_IRQ_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              en, clr, snap, rd;
    logic [2:0]        idx;
    logic [NCH*IW-1:0] inc;

    logic          rv_w, re_w, sv_w, irq_w, rv_s, re_s, sv_s, irq_s;
    logic [CW-1:0] rd_w, rd_s;
    logic [NCH-1:0] ovf_w, ovf_s;

    perf_event_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .INC_W(IW), .SAT_MODE(0)) u_wrap (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .evt_inc_i(inc),
        .snap_req_i(snap), .rd_req_i(rd), .rd_idx_i(idx),
        .rd_valid_o(rv_w), .rd_data_o(rd_w), .rd_err_o(re_w),
        .snap_valid_o(sv_w), .ovf_o(ovf_w), .irq_o(irq_w)
    );

    perf_event_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .INC_W(IW), .SAT_MODE(1)) u_sat (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .evt_inc_i(inc),
        .snap_req_i(snap), .rd_req_i(rd), .rd_idx_i(idx),
        .rd_valid_o(rv_s), .rd_data_o(rd_s), .rd_err_o(re_s),
        .snap_valid_o(sv_s), .ovf_o(ovf_s), .irq_o(irq_s)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer counters per channel.
    int lw[NCH], ls[NCH], sw[NCH], ss[NCH];
    bit mv;
    bit [NCH-1:0] ow, os;
    int edw, eds;
    bit erv, ere;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            lw[k] = 0; ls[k] = 0; sw[k] = 0; ss[k] = 0;
        end
        mv = 0; ow = '0; os = '0;
        edw = 0; eds = 0; erv = 0; ere = 0;
    endtask

    task automatic check_all(string tag);
        chk({tag, ":rv_w"}, rv_w, erv);
        chk({tag, ":rv_s"}, rv_s, erv);
        chk({tag, ":re_w"}, re_w, ere);
        chk({tag, ":re_s"}, re_s, ere);
        chk({tag, ":rd_w"}, rd_w, edw);
        chk({tag, ":rd_s"}, rd_s, eds);
        chk({tag, ":sv_w"}, sv_w, mv);
        chk({tag, ":sv_s"}, sv_s, mv);
        chk({tag, ":ovf_w"}, ovf_w, OVF_EN ? ow : '0);
        chk({tag, ":ovf_s"}, ovf_s, OVF_EN ? os : '0);
        chk({tag, ":irq_w"}, irq_w, OVF_EN & (|ow));
        chk({tag, ":irq_s"}, irq_s, OVF_EN & (|os));
    endtask

    task automatic tick(string tag);
        int s, iv;
        @(posedge clk);
        erv = rd;
        ere = 0;
        if (rd) begin
            if (!mv || int'(idx) >= NCH) begin
                ere = 1; edw = 0; eds = 0;
            end else begin
                edw = sw[idx]; eds = ss[idx];
            end
        end
        if (snap) begin
            for (int k = 0; k < NCH; k++) begin
                sw[k] = lw[k]; ss[k] = ls[k];
            end
            mv = 1; ow = '0; os = '0;
        end
        for (int k = 0; k < NCH; k++) begin
            iv = int'(inc[k*IW +: IW]);
            if (clr) begin
                lw[k] = 0; ls[k] = 0;
            end else if (en) begin
                s = lw[k] + iv;
                if (s > MAXV) ow[k] = 1'b1;
                lw[k] = s % (MAXV + 1);
                s = ls[k] + iv;
                if (s > MAXV) os[k] = 1'b1;
                ls[k] = (s > MAXV) ? MAXV : s;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        clr = 0; snap = 0; rd = 0; inc = '0;
    endtask

    task automatic set_inc(int ch, int v);
        inc = '0;
        inc[ch*IW +: IW] = IW'(v);
    endtask

    initial begin
        en = 1; idx = '0;
        idle();
        model_reset();
        #12;
        chk("reset_rd_valid", rv_w, 1'b0);
        chk("reset_snap_valid", sv_w, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // 1: async reset mid-activity, then read with no snapshot
        set_inc(0, 1);
        repeat (5) tick("t1_cnt");
        idle(); snap = 1;
        tick("t1_snap");
        snap = 0; rd = 1; idx = 3'd0;
        tick("t1_rd");
        chk("t1_rd_data", rd_w, 8'd5);
        rd = 0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("t1_async_rst");
        chk("t1_rst_rd_valid", rv_w, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        rd = 1; idx = 3'd0;
        tick("t1_rd_empty");
        chk("t1_empty_err", re_w, 1'b1);
        chk("t1_empty_data", rd_w, 8'd0);

        // 2: multi-increment on channel 3
        idle();
        set_inc(3, 3);
        repeat (4) tick("t2_cnt");
        idle(); snap = 1;
        tick("t2_snap");
        snap = 0; rd = 1; idx = 3'd3;
        tick("t2_rd");
        chk("t2_data", rd_w, 8'd12);
        chk("t2_err", re_w, 1'b0);

        // 3: wrap vs saturate at the 8-bit boundary
        idle(); clr = 1;
        tick("t3_clr");
        idle(); set_inc(0, 3);
        repeat (84) tick("t3_cnt");
        set_inc(0, 2);
        tick("t3_254");
        set_inc(0, 3);
        tick("t3_ovf");
        chk("t3_ovf_w0", ovf_w[0], OVF_EN);
        chk("t3_irq_s", irq_s, OVF_EN);
        idle(); snap = 1;
        tick("t3_snap");
        chk("t3_ovf_clr", ovf_w[0], 1'b0);
        snap = 0; rd = 1; idx = 3'd0;
        tick("t3_rd");
        chk("t3_wrap", rd_w, 8'd1);
        chk("t3_sat", rd_s, 8'd255);

        // 4: clr + snap + inc in the same cycle
        idle(); clr = 1;
        tick("t4_clr");
        idle(); set_inc(1, 2);
        repeat (5) tick("t4_cnt");
        clr = 1; snap = 1;
        tick("t4_combo");
        idle(); rd = 1; idx = 3'd1;
        tick("t4_rd_old");
        chk("t4_shadow", rd_w, 8'd10);
        idle(); snap = 1;
        tick("t4_snap2");
        idle(); rd = 1; idx = 3'd1;
        tick("t4_rd_live");
        chk("t4_live_zero", rd_w, 8'd0);

        // 5: global enable low, then out-of-range read
        idle(); en = 0;
        inc = {NCH{2'd1}};
        repeat (5) tick("t5_frozen");
        idle(); en = 1; snap = 1;
        tick("t5_snap");
        snap = 0; rd = 1;
        for (int k = 0; k < NCH; k++) begin
            idx = 3'(k);
            tick("t5_rd");
        end
        idx = 3'(NCH);
        tick("t5_oob");
        chk("t5_oob_err", re_w, 1'b1);
        chk("t5_oob_data", rd_w, 8'd0);

        // 6: read during recapture returns the old shadow value
        idle(); clr = 1;
        tick("t6_clr");
        idle(); set_inc(2, 3);
        repeat (2) tick("t6_cnt");
        set_inc(2, 1);
        tick("t6_cnt7");
        idle(); snap = 1;
        tick("t6_snap");
        set_inc(2, 2); snap = 0;
        tick("t6_live9");
        idle(); snap = 1; rd = 1; idx = 3'd2;
        tick("t6_rd_old");
        chk("t6_old", rd_w, 8'd7);
        idle(); rd = 1; idx = 3'd2;
        tick("t6_rd_new");
        chk("t6_new", rd_w, 8'd9);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            en   = ($urandom_range(0, 9) != 0);
            clr  = ($urandom_range(0, 29) == 0);
            snap = ($urandom_range(0, 7) == 0);
            rd   = $urandom_range(0, 1) == 1;
            idx  = 3'($urandom_range(0, 7));
            inc  = (NCH*IW)'($urandom);
            tick("rand");
        end
        idle();
        tick("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
